// File: rtl/seq_ctrl_cnt.sv
// Sequencing controller: arm on go, wait on x[GO_BIT], evaluate, then run action A or B and a timed hold.
// A saturating evaluation-visit counter diverts into a sticky DIVERT state once THRESH is reached.
module seq_ctrl_cnt #(
    parameter int X_W      = 6,
    parameter int CNT_W    = 4,
    parameter int THRESH   = 5,
    parameter int HOLD_CYC = 3,
    parameter int GO_BIT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             stop,
    input  logic             cnt_en,
    input  logic             clr_cnt,
    input  logic [X_W-1:0]   x,
    output logic             busy,
    output logic             act_a,
    output logic             act_b,
    output logic             done,
    output logic             divert,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ARM    = 4'd1,
        S_WAIT   = 4'd2,
        S_EVAL   = 4'd3,
        S_ACT_A  = 4'd4,
        S_ACT_B  = 4'd5,
        S_HOLD   = 4'd6,
        S_DONE   = 4'd7,
        S_DIVERT = 4'd8
    } state_t;

    localparam int TW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] THR       = CNT_W'(THRESH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] cnt_inc;
    logic             unused_x;

    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign unused_x = ^x;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            timer <= '0;
        end else if (state == S_DIVERT) begin
            if (clr_cnt) begin
                state <= S_IDLE;
                cnt   <= '0;
            end
        end else begin
            // clr wins over the EVAL increment; stop suppresses the increment
            if (clr_cnt)
                cnt <= '0;
            else if (state == S_EVAL && !stop)
                cnt <= cnt_inc;

            if (stop && state != S_IDLE) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE:  if (go) state <= S_ARM;
                    S_ARM:   state <= S_WAIT;
                    S_WAIT:  if (x[GO_BIT]) state <= S_EVAL;
                    S_EVAL: begin
                        if (cnt_en && cnt_inc >= THR) state <= S_DIVERT;
                        else if (x[0] && x[1])        state <= S_ACT_A;
                        else if (x[0])                state <= S_ACT_B;
                        else                          state <= S_WAIT;
                    end
                    S_ACT_A: begin
                        state <= S_HOLD;
                        timer <= '0;
                    end
                    S_ACT_B: if (x[2]) begin
                        state <= S_HOLD;
                        timer <= '0;
                    end
                    S_HOLD: begin
                        if (timer == HOLD_LAST) state <= S_DONE;
                        timer <= timer + 1'b1;
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy    = (state != S_IDLE) && (state <= S_DIVERT);
    assign act_a   = (state == S_ACT_A);
    assign act_b   = (state == S_ACT_B);
    assign done    = (state == S_DONE);
    assign divert  = (state == S_DIVERT);
    assign state_o = state;
    assign cnt_o   = cnt;

endmodule

// File: doc/seq_ctrl_cnt.md
Name: seq_ctrl_cnt

Overview:
Parametrised sequencing controller: a Moore FSM that arms on `go`, waits on a selectable condition input, then branches into one of two action paths followed by a timed hold. A saturating evaluation-visit counter diverts the FSM into a sticky DIVERT state once a programmable threshold is reached, when counting is enabled. It is the generalised successor of the team's fixed-width controller benchmarks: input width, counter width, threshold, hold length and go-condition select are all parameters. State and count are observable for benchmark instrumentation.

Parameters:
X_W, 6, width of condition input vector x; minimum 3.
CNT_W, 4, width of evaluation-visit counter.
THRESH, 5, divert threshold; legal range 1..2^CNT_W-1.
HOLD_CYC, 3, cycles spent in HOLD; minimum 1.
GO_BIT, 3, index into x of the wait/go condition; range 0..X_W-1.

Ports:
clk  input  1  clock; all state updates on falling edge.
rst  input  1  asynchronous, active-high reset.
go  input  1  start request, sampled in IDLE.
stop  input  1  abort request.
cnt_en  input  1  enables the divert check; counting itself is always active.
clr_cnt  input  1  clears the counter; also releases DIVERT.
x  input  X_W  condition inputs.
busy  output  1  high in every state except IDLE.
act_a  output  1  high in ACT_A.
act_b  output  1  high in ACT_B.
done  output  1  high in DONE.
divert  output  1  high in DIVERT.
state_o  output  4  current state encoding.
cnt_o  output  CNT_W  current counter value.

Behaviour:
- State encodings: IDLE=0, ARM=1, WAIT=2, EVAL=3, ACT_A=4, ACT_B=5, HOLD=6, DONE=7, DIVERT=8.
- Clocking and reset:
  - Registers update on negedge clk.
  - rst high, at any time including mid-operation, forces state=IDLE, cnt=0, hold timer=0 immediately.
  - Outputs after reset: busy=act_a=act_b=done=divert=0, state_o=0, cnt_o=0.
- Outputs are combinational decodes of the current state only (Moore). Unused encodings 9..15 drive all flags 0 and transition to IDLE on the next edge.
- Transitions, evaluated in priority order within each state:
  - IDLE: go -> ARM; else stay.
  - ARM: -> WAIT unconditionally; one cycle.
  - WAIT: x[GO_BIT] -> EVAL; else stay.
  - EVAL:
    - On the edge leaving EVAL, cnt <= cnt+1, saturating at 2^CNT_W-1.
    - If cnt_en and the incremented value >= THRESH -> DIVERT.
    - Else x[0]&x[1] -> ACT_A; else x[0] -> ACT_B; else -> WAIT.
  - ACT_A: -> HOLD unconditionally.
  - ACT_B: x[2] -> HOLD; else stay.
  - HOLD:
    - Timer is cleared on entry and increments each cycle.
    - Exits to DONE on the edge where timer==HOLD_CYC-1, so the state is held exactly HOLD_CYC cycles.
  - DONE: -> IDLE unconditionally; done is a one-cycle pulse.
  - DIVERT: sticky; stays until clr_cnt, then -> IDLE with cnt <= 0 on the same edge.
- stop:
  - In any state other than IDLE or DIVERT, stop forces IDLE on the next edge.
  - stop overrides all other transitions, including the EVAL increment (no count taken).
  - cnt is preserved.
- clr_cnt outside DIVERT: cnt <= 0 on the next edge.
  - Takes priority over the EVAL increment on the same edge (result 0).
  - Does not change state.
- Counter saturation: cnt holds at 2^CNT_W-1 and never wraps.
- cnt_en low: EVAL never diverts and the counter still counts.

Test Plan:
- Reset check: pulse rst mid-HOLD -> state_o=0, cnt_o=0, all flags 0 before the next clk edge.
- Path A (defaults): go=1, then x=6'b001011 -> state sequence IDLE, ARM, WAIT, EVAL, ACT_A, HOLD x3 cycles, DONE (1-cycle pulse), IDLE; cnt_o=1.
- Path B stall: x[0]=1, x[1]=0, x[2]=0 at EVAL -> act_b stays high; raising x[2] -> HOLD on the next edge.
- Divert: cnt_en=1, run 5 passes -> 5th EVAL goes to DIVERT with cnt_o=5; go is ignored; clr_cnt=1 -> IDLE with cnt_o=0.
- Saturation: cnt_en=0, CNT_W=4, 20 passes -> cnt_o stops at 15; no divert.
- Stop/clr precedence: assert stop and clr_cnt together in EVAL with cnt=3 -> IDLE and cnt_o=0 (no increment).
